// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons sharing one update datapath.
// Each tick starts a sweep that updates one neuron per clock edge.
module lif_neuron_array #(
  parameter int N_NEURONS = 4,
  parameter int W         = 8,
  parameter int REFRAC_W  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic [N_NEURONS*W-1:0]        current_in,
  input  logic [W-1:0]                  threshold,
  input  logic [2:0]                    leak_shift,
  input  logic [REFRAC_W-1:0]           refrac_cycles,
  input  logic [$clog2(N_NEURONS)-1:0]  probe_idx,
  output logic                          busy,
  output logic                          done,
  output logic [N_NEURONS-1:0]          spike_out,
  output logic                          overrun,
  output logic [W-1:0]                  probe_v
);

  localparam int IDX_W = $clog2(N_NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [W-1:0]           v_q [N_NEURONS];
  logic [W-1:0]           v_d [N_NEURONS];
  logic [REFRAC_W-1:0]    refrac_q [N_NEURONS];
  logic [REFRAC_W-1:0]    refrac_d [N_NEURONS];
  logic [N_NEURONS*W-1:0] cur_lat_q, cur_lat_d;
  logic [W-1:0]           thr_lat_q, thr_lat_d;
  logic [2:0]             shift_lat_q, shift_lat_d;
  logic [REFRAC_W-1:0]    rc_lat_q, rc_lat_d;
  logic [N_NEURONS-1:0]   flags_q, flags_d;
  logic [N_NEURONS-1:0]   spike_q, spike_d;
  logic                   done_q, done_d;
  logic                   overrun_q, overrun_d;
  logic [W-1:0]           probe_q, probe_d;

  logic [W-1:0]           cur_v_s;
  logic [W-1:0]           cur_i_s;
  logic [REFRAC_W-1:0]    cur_r_s;
  logic [W-1:0]           leak_s;
  logic [W:0]             sum_s;
  logic [W-1:0]           vn_s;
  logic                   fire_s;
  logic                   spike_now_s;

  // Datapath for the neuron selected by idx: leak, integrate, saturate, compare.
  always_comb begin
    cur_v_s = v_q[idx_q];
    cur_r_s = refrac_q[idx_q];
    cur_i_s = cur_lat_q[idx_q*W +: W];
    if (shift_lat_q != 3'd0) begin
      leak_s = cur_v_s >> shift_lat_q;
    end else begin
      leak_s = '0;
    end
    // leak never exceeds V, so the W+1 bit sum cannot go negative
    sum_s = {1'b0, cur_v_s} - {1'b0, leak_s} + {1'b0, cur_i_s};
    if (sum_s[W]) begin
      vn_s = '1;
    end else begin
      vn_s = sum_s[W-1:0];
    end
    fire_s = (vn_s >= thr_lat_q);
  end

  // Sweep control, per-neuron state update and output next-state.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    v_d         = v_q;
    refrac_d    = refrac_q;
    cur_lat_d   = cur_lat_q;
    thr_lat_d   = thr_lat_q;
    shift_lat_d = shift_lat_q;
    rc_lat_d    = rc_lat_q;
    flags_d     = flags_q;
    spike_d     = spike_q;
    done_d      = 1'b0;
    overrun_d   = 1'b0;
    spike_now_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          cur_lat_d   = current_in;
          thr_lat_d   = threshold;
          shift_lat_d = leak_shift;
          rc_lat_d    = refrac_cycles;
          idx_d       = '0;
          flags_d     = '0;
          state_d     = S_SWEEP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SWEEP: begin
        overrun_d = tick;
        if (cur_r_s != '0) begin
          refrac_d[idx_q] = cur_r_s - {{(REFRAC_W-1){1'b0}}, 1'b1};
          v_d[idx_q]      = '0;
          spike_now_s     = 1'b0;
        end else if (fire_s) begin
          refrac_d[idx_q] = rc_lat_q;
          v_d[idx_q]      = '0;
          spike_now_s     = 1'b1;
        end else begin
          v_d[idx_q]      = vn_s;
          spike_now_s     = 1'b0;
        end
        flags_d[idx_q] = spike_now_s;
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          spike_d = flags_d;
        end else begin
          idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Membrane potential probe; indices beyond the array read as zero.
  always_comb begin
    if (int'(probe_idx) < N_NEURONS) begin
      probe_d = v_q[probe_idx];
    end else begin
      probe_d = '0;
    end
  end

  // State registers with synchronous reset that also aborts a sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      v_q         <= '{default: '0};
      refrac_q    <= '{default: '0};
      cur_lat_q   <= '0;
      thr_lat_q   <= '0;
      shift_lat_q <= 3'd0;
      rc_lat_q    <= '0;
      flags_q     <= '0;
      spike_q     <= '0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      probe_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      v_q         <= v_d;
      refrac_q    <= refrac_d;
      cur_lat_q   <= cur_lat_d;
      thr_lat_q   <= thr_lat_d;
      shift_lat_q <= shift_lat_d;
      rc_lat_q    <= rc_lat_d;
      flags_q     <= flags_d;
      spike_q     <= spike_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      probe_q     <= probe_d;
    end
  end

  assign busy      = (state_q == S_SWEEP);
  assign done      = done_q;
  assign spike_out = spike_q;
  assign overrun   = overrun_q;
  assign probe_v   = probe_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Self-checking bench for lif_neuron_array: directed scenarios plus randomized
// timesteps compared against a whole-timestep arithmetic reference model.
module tb_lif_neuron_array;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int RW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           tick;
  logic [N*W-1:0] current_in;
  logic [W-1:0]   threshold;
  logic [2:0]     leak_shift;
  logic [RW-1:0]  refrac_cycles;
  logic [1:0]     probe_idx;
  logic           busy;
  logic           done;
  logic [N-1:0]   spike_out;
  logic           overrun;
  logic [W-1:0]   probe_v;

  lif_neuron_array #(.N_NEURONS(N), .W(W), .REFRAC_W(RW)) dut (
    .clk(clk), .rst(rst), .tick(tick), .current_in(current_in),
    .threshold(threshold), .leak_shift(leak_shift), .refrac_cycles(refrac_cycles),
    .probe_idx(probe_idx), .busy(busy), .done(done), .spike_out(spike_out),
    .overrun(overrun), .probe_v(probe_v)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int mv[N];
  int mr[N];
  int cur[N];
  int thr, ls, rc;
  logic [N-1:0] exp_sp;
  int v0_tab[11] = '{60, 105, 139, 165, 184, 198, 0, 0, 0, 0, 60};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_cfg();
    for (int k = 0; k < N; k++) current_in[k*W +: W] = W'(cur[k]);
    threshold     = W'(thr);
    leak_shift    = 3'(ls);
    refrac_cycles = RW'(rc);
  endtask

  // One full timestep for all neurons, straight from the neuron rules.
  function automatic void model_step();
    int s;
    for (int k = 0; k < N; k++) begin
      if (mr[k] > 0) begin
        mr[k]     = mr[k] - 1;
        mv[k]     = 0;
        exp_sp[k] = 1'b0;
      end else begin
        s = mv[k] - ((ls != 0) ? (mv[k] >> ls) : 0) + cur[k];
        if (s > 255) s = 255;
        if (s >= thr) begin
          exp_sp[k] = 1'b1;
          mv[k]     = 0;
          mr[k]     = rc;
        end else begin
          exp_sp[k] = 1'b0;
          mv[k]     = s;
        end
      end
    end
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      mv[k] = 0;
      mr[k] = 0;
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    tick = 1'b0;
    step();
    rst = 1'b0;
    model_clear();
  endtask

  // retick: cycle after the tick edge on which a second tick is driven (0 = none).
  task automatic run_sweep(input int retick, input bit scramble);
    apply_cfg();
    model_step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    check_eq("busy_start", busy, 1);
    check_eq("ovr_start", overrun, 0);
    check_eq("done_start", done, 0);
    if (scramble) begin
      current_in    = $urandom;
      threshold     = W'($urandom);
      leak_shift    = 3'($urandom);
      refrac_cycles = RW'($urandom);
    end
    for (int c = 1; c <= N; c++) begin
      tick = (c == retick);
      step();
      tick = 1'b0;
      check_eq("overrun", overrun, (c == retick) ? 1 : 0);
      if (c < N) begin
        check_eq("busy_mid", busy, 1);
        check_eq("done_mid", done, 0);
      end else begin
        check_eq("busy_end", busy, 0);
        check_eq("done_end", done, 1);
        check_eq("spikes", spike_out, exp_sp);
      end
    end
  endtask

  task automatic check_v(input string tag);
    for (int k = 0; k < N; k++) begin
      probe_idx = 2'(k);
      step();
      if (k == 0) begin
        check_eq("done_gone", done, 0);
        check_eq("busy_idle", busy, 0);
      end
      check_eq(tag, probe_v, mv[k]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    tick = 1'b0;
    probe_idx = 2'd0;
    for (int k = 0; k < N; k++) cur[k] = 0;
    thr = 200; ls = 2; rc = 3;
    apply_cfg();
    step();
    step();
    rst = 1'b0;
    model_clear();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ovr", overrun, 0);
    check_eq("rst_spk", spike_out, 0);
    check_eq("rst_probe", probe_v, 0);

    // threshold 0: every neuron fires, then back-to-back sweep finds all refractory
    thr = 0;
    for (int k = 0; k < N; k++) cur[k] = $urandom_range(0, 255);
    run_sweep(0, 1'b0);
    check_eq("thr0_all", spike_out, 4'b1111);
    run_sweep(0, 1'b0);
    // reset mid-sweep discards the partial sweep
    thr = 200;
    apply_cfg();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_clear();
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_spk", spike_out, 0);
    check_eq("mid_rst_done", done, 0);
    check_v("mid_rst_v");

    // constant drive into neuron 0 with refractory recovery
    do_reset();
    thr = 200; ls = 2; rc = 3;
    cur[0] = 60; cur[1] = 0; cur[2] = 0; cur[3] = 0;
    for (int t = 0; t < 11; t++) begin
      run_sweep(0, 1'b0);
      if (t == 6) check_eq("t2_spike7", spike_out, 4'b0001);
      probe_idx = 2'd0;
      repeat (6) step();
      check_eq("t2_v0", probe_v, v0_tab[t]);
    end

    // saturation instead of wrap
    do_reset();
    thr = 255; ls = 0; rc = 3;
    cur[0] = 0; cur[1] = 200; cur[2] = 0; cur[3] = 0;
    run_sweep(0, 1'b0);
    probe_idx = 2'd1;
    step();
    check_eq("sat_v1", probe_v, 200);
    run_sweep(0, 1'b0);
    check_eq("sat_spk", spike_out, 4'b0010);
    check_v("sat_v");

    // tick while busy: overrun pulse, single update
    do_reset();
    thr = 200; ls = 2; rc = 3;
    for (int k = 0; k < N; k++) cur[k] = $urandom_range(0, 150);
    run_sweep(2, 1'b0);
    check_v("ovr_v");

    // randomized timesteps with mid-sweep config changes
    do_reset();
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < N; k++) cur[k] = $urandom_range(0, 255) >> $urandom_range(0, 2);
      thr = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(40, 255);
      ls  = $urandom_range(0, 7);
      rc  = $urandom_range(0, 5);
      run_sweep(($urandom_range(0, 4) == 0) ? $urandom_range(1, N) : 0, 1'b1);
      if ($urandom_range(0, 1) == 1) check_v("rnd_v");
    end
    check_v("rnd_final_v");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
